sync_fifo_prog: RTL

Parametrised synchronous FIFO, the successor to the fixed-size FIFO. It adds configurable width and depth (power-of-two not required), programmable almost-full/almost-empty thresholds, and an occupancy count. It also adds a synchronous flush, pass-through write at full, and a first-word-fall-through (FWFT) read mode. It is a single-clock buffer between a producer and a consumer inside one clock domain.

---
 rtl/sync_fifo_prog.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable level thresholds, synchronous flush,
// pass-through write at full, and optional first-word-fall-through read port.
module sync_fifo_prog #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AF_LEVEL   = DEPTH - 1,
   parameter int unsigned AE_LEVEL   = 1,
   parameter int unsigned FWFT       = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           wr_en,
   input  logic [DATA_WIDTH-1:0]          data_in,
   input  logic                           rd_en,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           rd_valid,
   output logic                           wr_ack,
   output logic                           overflow,
   output logic                           underflow,
   output logic                           full,
   output logic                           empty,
   output logic                           almostfull,
   output logic                           almostempty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
   localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AeCnt    = CW'(AE_LEVEL);

   if (!(DEPTH >= 2 && AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH))
   begin : g_bad_params
      $error("sync_fifo_prog: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
   end

   if (FWFT > 1) begin : g_bad_fwft
      $error("sync_fifo_prog: FWFT must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ack_q, wr_ack_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          rd_acc, wr_acc, mem_we;

   // Explicit wrap so non-power-of-two depths never index past the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LastPtr) ? '0 : p + PW'(1);
   endfunction

   assign full        = (count_q == DepthCnt);
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= AfCnt);
   assign almostempty = (count_q <= AeCnt);
   assign count       = count_q;
   assign wr_ack      = wr_ack_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_en);
   assign mem_we = wr_acc && !flush && !rst;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      wr_ack_d    = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ack_d    = wr_acc;
         overflow_d  = wr_en && !wr_acc;
         underflow_d = rd_en && empty;
         if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
         unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= data_in;
   end

   if (FWFT != 0) begin : g_fwft
      assign data_out = mem_q[rd_ptr_q];
      assign rd_valid = !empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
         dout_d     = dout_q;
         rd_valid_d = 1'b0;
         if (!flush) begin
            rd_valid_d = rd_acc;
            if (rd_acc) dout_d = mem_q[rd_ptr_q];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign data_out = dout_q;
      assign rd_valid = rd_valid_q;
   end

endmodule
